demux_lane_ctrl: RTL and testbench

DEMUX_LANE_CTRL -- requirements
Module: demux_lane_ctrl

---
 rtl/demux_ctrl_pkg.sv | 26 ++
 rtl/lane_counter.sv | 47 ++++
 rtl/demux_lane_ctrl.sv | 166 ++++++++++++++++
 tb/tb_demux_lane_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the demux lane controller: one-hot state encodings,
// default widths and small state-classification helpers.
package demux_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 3;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_e;

  // States in which an upstream word may be taken.
  function automatic logic can_accept(input state_e s);
    return (s == ST_IDLE) || (s == ST_ACTIVE);
  endfunction

  // States in which a pop on an empty lane is a protocol violation.
  function automatic logic checks_pops(input state_e s);
    return (s == ST_INIT) || (s == ST_IDLE) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/lane_counter.sv
// Per-lane occupancy counter: tracks words pushed into and popped from one
// downstream lane and flags when the post-update count reaches its threshold.
module lane_counter
  import demux_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] count,
  output logic             pause_req,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    underflow  = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (count != CNT_MAX) count_next = count + CNT_W'(1);
      end
      2'b01: begin
        if (count == '0) underflow  = 1'b1;
        else             count_next = count - CNT_W'(1);
      end
      default: ;  // idle, or push and pop cancel out
    endcase
  end

  // A zero threshold is always met, so that lane holds pause permanently.
  assign pause_req = (count_next >= thresh);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) count <= '0;
    else          count <= count_next;
  end

endmodule

// File: rtl/demux_lane_ctrl.sv
// Control FSM for the existing 1x2 demux: accepts upstream words, steers them to
// lane 0/1 via sel/push, and tracks per-lane occupancy for backpressure.
// Define DEMUX_LANE_CTRL_RR_EN for round-robin lane choice; otherwise data_in[0] routes.
module demux_lane_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [CNT_W-1:0]  umbral_alto0,
  input  logic [CNT_W-1:0]  umbral_alto1,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop0,
  input  logic              pop1,
  output logic              push0,
  output logic              push1,
  output logic [DATA_W-1:0] data_out,
  output logic              sel,
  output logic              pause,
  output logic              idle,
  output logic              error_out,
  output logic [4:0]        state
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] th0, th1;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             pause_req0, pause_req1;
  logic             underflow0, underflow1;
  logic             accept;
  logic             lane;
  logic             err;

  assign accept = valid_in && !pause && can_accept(state_q);

  // ---------------------------------------------------------------------------
  // Lane selection
  // ---------------------------------------------------------------------------
`ifdef DEMUX_LANE_CTRL_RR_EN
  logic rr_ptr;
  logic full0, full1;

  assign full0 = (cnt0 >= th0);
  assign full1 = (cnt1 >= th1);

  // Skip the preferred lane only when it is full and the other still has room.
  always_comb begin
    lane = rr_ptr;
    if (rr_ptr ? (full1 && !full0) : (full0 && !full1)) lane = ~rr_ptr;
  end

  // Pointing past the lane just used covers both plain alternation and a skip.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)    rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~lane;
  end
`else
  assign lane = data_in[0];
`endif

  // ---------------------------------------------------------------------------
  // Occupancy counters
  // ---------------------------------------------------------------------------
  lane_counter #(.CNT_W(CNT_W)) u_lane0 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push0),
    .pop       (pop0),
    .thresh    (th0),
    .count     (cnt0),
    .pause_req (pause_req0),
    .underflow (underflow0)
  );

  lane_counter #(.CNT_W(CNT_W)) u_lane1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push1),
    .pop       (pop1),
    .thresh    (th1),
    .count     (cnt1),
    .pause_req (pause_req1),
    .underflow (underflow1)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    if (can_accept(state_q) && valid_in && pause)        err = 1'b1;
    if (checks_pops(state_q) && (underflow0 || underflow1)) err = 1'b1;

    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT: begin
        if (err)        state_d = ST_ERROR;
        else if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (err)         state_d = ST_ERROR;
        else if (init)   state_d = ST_INIT;
        else if (accept) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err)       state_d = ST_ERROR;
        else if (init) state_d = ST_INIT;
        else if ((cnt0 == '0) && (cnt1 == '0) && !valid_in) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  // Thresholds track the inputs for as long as init is held in INIT.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      th0 <= '1;
      th1 <= '1;
    end else if ((state_q == ST_INIT) && init) begin
      th0 <= umbral_alto0;
      th1 <= umbral_alto1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered demux drive and backpressure
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push0    <= 1'b0;
      push1    <= 1'b0;
      sel      <= 1'b0;
      data_out <= '0;
      pause    <= 1'b0;
    end else begin
      push0 <= accept && !lane;
      push1 <= accept &&  lane;
      if (accept) begin
        sel      <= lane;
        data_out <= data_in;
      end
      pause <= pause_req0 || pause_req1;
    end
  end

  assign idle      = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);
  assign state     = state_q;

  // Structural invariants of the controller.
  assert property (@(posedge clk) disable iff (!reset_L) !(push0 && push1));
  assert property (@(posedge clk) disable iff (!reset_L) $onehot(state_q));

endmodule

// File: tb/tb_demux_lane_ctrl.sv
// Scenario bench for demux_lane_ctrl: expected pushes are queued when a word is
// driven and matched against push/sel/data_out when the controller emits them.
`timescale 1ns/1ps
module tb_demux_lane_ctrl;
  import demux_ctrl_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              init = 1'b0;
  logic [CNT_W-1:0]  umbral_alto0 = '0;
  logic [CNT_W-1:0]  umbral_alto1 = '0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              pop0 = 1'b0;
  logic              pop1 = 1'b0;
  logic              push0, push1, sel, pause, idle, error_out;
  logic [DATA_W-1:0] data_out;
  logic [4:0]        state;

  typedef struct {
    logic              lane;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_ptr = 1'b0;

  demux_lane_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_alto0 (umbral_alto0),
    .umbral_alto1 (umbral_alto1),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .pop0         (pop0),
    .pop1         (pop1),
    .push0        (push0),
    .push1        (push1),
    .data_out     (data_out),
    .sel          (sel),
    .pause        (pause),
    .idle         (idle),
    .error_out    (error_out),
    .state        (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic exp_lane(input logic [DATA_W-1:0] d);
`ifdef DEMUX_LANE_CTRL_RR_EN
    return exp_ptr;
`else
    return d[0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word that the controller is expected to accept at the next edge.
  task automatic send(input logic [DATA_W-1:0] d);
    exp_t e;
    e.lane = exp_lane(d);
    e.data = d;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
    exp_ptr  = ~e.lane;
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (push0 || push1) begin
        checks++;
        if (push0 && push1) begin
          errors++;
          $display("FAIL dual_push got push0=1 push1=1 want one strobe");
        end else if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_push got push0=%0b push1=%0b data=%h want no push",
                   push0, push1, data_out);
        end else begin
          e = sb_q.pop_front();
          if (push1 !== e.lane || push0 !== !e.lane || sel !== e.lane ||
              data_out !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL sb_push got lane=%0b sel=%0b data=%h cyc=%0d want lane=%0b data=%h cyc=%0d",
                     push1, sel, data_out, cyc, e.lane, e.data, e.cyc);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = sb_q.pop_front();
        $display("FAIL missed_push got none at cyc=%0d want lane=%0b data=%h", cyc, e.lane, e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    exp_ptr = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== 5'b00001) begin
      errors++; $display("FAIL reset_state got %b want 00001", state);
    end
    checks++;
    if ({push0, push1, sel, pause, error_out, idle} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {push0, push1, sel, pause, error_out, idle});
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h want 00", data_out);
    end
    checks++;
    if ({dut.th0, dut.th1, dut.cnt0, dut.cnt1} !== {3'd7, 3'd7, 3'd0, 3'd0}) begin
      errors++; $display("FAIL reset_regs got th=%0d/%0d cnt=%0d/%0d want 7/7 0/0",
                         dut.th0, dut.th1, dut.cnt0, dut.cnt1);
    end
  endtask

  // Release reset with init held for two cycles: RESET, INIT, INIT, IDLE.
  task automatic test_init(input logic [CNT_W-1:0] u0, input logic [CNT_W-1:0] u1);
    logic [4:0] want [4];
    want[0] = 5'b00001; want[1] = 5'b00010; want[2] = 5'b00010; want[3] = 5'b00100;
    init = 1'b1;
    umbral_alto0 = u0;
    umbral_alto1 = u1;
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) init = 1'b0;
      checks++;
      if (state !== want[i]) begin
        errors++; $display("FAIL init_seq%0d got %b want %b", i, state, want[i]);
      end
      if (i < 3) tick();
    end
    checks++;
    if ({dut.th0, dut.th1} !== {u0, u1} || idle !== 1'b1) begin
      errors++; $display("FAIL init_thresh got th=%0d/%0d idle=%0b want %0d/%0d idle=1",
                         dut.th0, dut.th1, idle, u0, u1);
    end
  endtask

  task automatic drain_check(input string name);
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL %s_drain got %0d pending want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_routing();
    send(8'h10); send(8'h11); send(8'h13);
    tick(); tick();
    checks++;
    if ({dut.cnt0, dut.cnt1} !== {3'd1, 3'd2} || state !== 5'b01000) begin
      errors++; $display("FAIL route_counts got %0d/%0d state=%b want 1/2 state=01000",
                         dut.cnt0, dut.cnt1, state);
    end
    send(8'h15);
    pop1 = 1'b1;
    tick();
    pop1 = 1'b0;
    checks++;
    if (dut.cnt1 !== 3'd2) begin
      errors++; $display("FAIL push_pop_same got cnt1=%0d want 2", dut.cnt1);
    end
    pop0 = 1'b1; tick(); pop0 = 1'b0;
    pop1 = 1'b1; tick(); tick(); pop1 = 1'b0;
    tick();
    checks++;
    if (state !== 5'b00100 || idle !== 1'b1 || {dut.cnt0, dut.cnt1} !== 6'd0) begin
      errors++; $display("FAIL route_idle got state=%b cnt=%0d/%0d want 00100 0/0",
                         state, dut.cnt0, dut.cnt1);
    end
    drain_check("route");
  endtask

  task automatic test_rr();
    for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i));
    tick(); tick();
    checks++;
    if ({dut.cnt0, dut.cnt1} !== {3'd2, 3'd2}) begin
      errors++; $display("FAIL rr_counts got %0d/%0d want 2/2", dut.cnt0, dut.cnt1);
    end
    pop0 = 1'b1; pop1 = 1'b1;
    tick(); tick();
    pop0 = 1'b0; pop1 = 1'b0;
    tick();
    checks++;
    if (state !== 5'b00100) begin
      errors++; $display("FAIL rr_idle got %b want 00100", state);
    end
    drain_check("rr");
  endtask

  task automatic test_backpressure();
    init = 1'b1;
    umbral_alto0 = 3'd2;
    umbral_alto1 = 3'd2;
    tick(); tick();
    init = 1'b0;
    tick();
    checks++;
    if (state !== 5'b00100 || {dut.th0, dut.th1} !== {3'd2, 3'd2}) begin
      errors++; $display("FAIL reinit got state=%b th=%0d/%0d want 00100 2/2", state, dut.th0, dut.th1);
    end
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    tick();
    checks++;
    if (pause !== 1'b1 || {dut.cnt0, dut.cnt1} !== {3'd2, 3'd2}) begin
      errors++; $display("FAIL bp_pause got pause=%0b cnt=%0d/%0d want 1 2/2", pause, dut.cnt0, dut.cnt1);
    end
    pop0 = 1'b1; tick(); pop0 = 1'b0;
    checks++;
    if (pause !== 1'b1) begin
      errors++; $display("FAIL bp_one_full got pause=%0b want 1", pause);
    end
    pop1 = 1'b1; tick(); pop1 = 1'b0;
    checks++;
    if (pause !== 1'b0 || {dut.cnt0, dut.cnt1} !== {3'd1, 3'd1}) begin
      errors++; $display("FAIL bp_release got pause=%0b cnt=%0d/%0d want 0 1/1", pause, dut.cnt0, dut.cnt1);
    end
    drain_check("bp");
  endtask

  task automatic test_error();
    int waited;
    send(8'h30);
    waited = 0;
    while (pause !== 1'b1 && waited < 6) begin
      tick();
      waited++;
    end
    checks++;
    if (pause !== 1'b1) begin
      errors++; $display("FAIL err_wait_pause got pause=%0b want 1", pause);
    end
    valid_in = 1'b1;
    data_in  = 8'h31;
    tick();
    valid_in = 1'b0;
    checks++;
    if (state !== 5'b10000 || error_out !== 1'b1) begin
      errors++; $display("FAIL err_enter got state=%b err=%0b want 10000 1", state, error_out);
    end
    repeat (3) tick();
    checks++;
    if (state !== 5'b10000 || error_out !== 1'b1 || idle !== 1'b0) begin
      errors++; $display("FAIL err_hold got state=%b err=%0b want 10000 1", state, error_out);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL err_sb got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
    reset_L = 1'b0;
    exp_ptr = 1'b0;
    #1;
    checks++;
    if (state !== 5'b00001 || error_out !== 1'b0) begin
      errors++; $display("FAIL err_reset got state=%b err=%0b want 00001 0", state, error_out);
    end
  endtask

  task automatic test_mid_reset();
    test_init(3'd3, 3'd5);
    valid_in = 1'b1;
    data_in  = 8'h40;
    @(negedge clk);
    reset_L = 1'b0;
    exp_ptr = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    reset_L  = 1'b1;
    checks++;
    if (state !== 5'b00001 || {push0, push1, sel, pause, error_out, idle} !== 6'b0 ||
        data_out !== 8'h00) begin
      errors++; $display("FAIL mid_reset_out got state=%b flags=%b data=%h want 00001 000000 00",
                         state, {push0, push1, sel, pause, error_out, idle}, data_out);
    end
    checks++;
    if ({dut.th0, dut.th1, dut.cnt0, dut.cnt1} !== {3'd7, 3'd7, 3'd0, 3'd0}) begin
      errors++; $display("FAIL mid_reset_regs got th=%0d/%0d cnt=%0d/%0d want 7/7 0/0",
                         dut.th0, dut.th1, dut.cnt0, dut.cnt1);
    end
    tick();
    checks++;
    if ({push0, push1} !== 2'b00 || state !== 5'b00010) begin
      errors++; $display("FAIL mid_reset_after got push=%b state=%b want 00 00010", {push0, push1}, state);
    end
    tick();
    checks++;
    if (state !== 5'b00100) begin
      errors++; $display("FAIL mid_reset_idle got %b want 00100", state);
    end
    send(8'h42);
    send(8'h43);
    drain_check("recover");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_init(3'd3, 3'd5);
`ifdef DEMUX_LANE_CTRL_RR_EN
    test_rr();
`else
    test_routing();
`endif
    test_backpressure();
    test_error();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
